// File: rtl/instr_mem.sv
// 16 x 9-bit instruction memory with a streaming program loader and a registered fetch port.
// Define IMEM_PARITY_EN to store a parity bit per word and flag parity errors on fetch.
module instr_mem (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [8:0] load_data,
  input  logic       load_par,
  output logic       load_ready,
  input  logic [3:0] PC_CURR,
  output logic [8:0] INS,
  output logic       set_pc,
  output logic       load_done,
  output logic       parity_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

`ifdef IMEM_PARITY_EN
  localparam int MW = 10;
`else
  localparam int MW = 9;
`endif

  // Handshake: a load word moves on any rising edge where load_valid and
  // load_ready are both 1; load_ready depends only on the FSM state.
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [3:0]    wr_ptr;
  logic          xfer;
  logic          start_load;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] fetch_word;
  logic [MW-1:0] mem [16];

  assign load_ready = (state == LOAD);
  assign load_done  = (state == FLUSH);
  assign set_pc     = (state != RUN);
  assign xfer       = load_ready & load_valid;
  assign start_load = load_start & ((state == IDLE) | (state == RUN));

`ifdef IMEM_PARITY_EN
  assign wr_word = {load_par, load_data};
`else
  logic unused_par;
  assign unused_par = load_par;
  assign wr_word    = load_data;
`endif

  assign fetch_word = mem[PC_CURR];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = LOAD;
      LOAD:    if (xfer && (wr_ptr == 4'd15)) state_nxt = FLUSH;
      FLUSH:   state_nxt = RUN;
      RUN:     if (load_start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= 4'd0;
    end else begin
      state <= state_nxt;
      if (start_load) begin
        wr_ptr <= 4'd0;
      end else if (xfer) begin
        wr_ptr <= wr_ptr + 4'd1;
      end
    end
  end

  // Storage has no reset so a program survives a reset or an aborted load.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      INS <= 9'd0;
    end else if (state == RUN) begin
      INS <= fetch_word[8:0];
    end else begin
      INS <= 9'd0;
    end
  end

`ifdef IMEM_PARITY_EN
  // A reload clears the flag even if the final RUN fetch on that edge is bad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (start_load) begin
      parity_err <= 1'b0;
    end else if ((state == RUN) && (^fetch_word)) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: reset, back-to-back and stalled loads, aborted load, reload from RUN.
module tb_instr_mem;

  logic       clk;
  logic       rst_n;
  logic       load_start;
  logic       load_valid;
  logic [8:0] load_data;
  logic       load_par;
  logic       load_ready;
  logic [3:0] PC_CURR;
  logic [8:0] INS;
  logic       set_pc;
  logic       load_done;
  logic       parity_err;

  int checks = 0;
  int errors = 0;
  int bad_par_idx = -1;
  logic [8:0] exp_mem [16];

  instr_mem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_par   (load_par),
    .load_ready (load_ready),
    .PC_CURR    (PC_CURR),
    .INS        (INS),
    .set_pc     (set_pc),
    .load_done  (load_done),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one full 16-word load; gap=1 drops load_valid every other cycle.
  task automatic load_seq(input bit do_start, input logic [8:0] base,
                          input logic [8:0] step, input bit gap);
    int accepted;
    int cyc;
    logic v;
    if (do_start) begin
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
    end
    accepted = 0;
    cyc = 0;
    while (accepted < 16 && cyc < 200) begin
      v = gap ? ((cyc % 2) == 0) : 1'b1;
      load_valid = v;
      load_data  = base + step * accepted[8:0];
      load_par   = (^load_data) ^ (accepted == bad_par_idx);
      // load_start must be ignored mid-load; pulse it during a stall.
      load_start = gap && (cyc == 5);
      check("ready_in_load", {15'd0, load_ready}, 16'd1);
      check("setpc_in_load", {15'd0, set_pc}, 16'd1);
      check("done_in_load", {15'd0, load_done}, 16'd0);
      if (cyc > 0) check("ins_in_load", {7'd0, INS}, 16'd0);
      tick();
      if (v) begin
        exp_mem[accepted] = load_data;
        accepted++;
      end
      cyc++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    check("load_accepted", accepted[15:0], 16'd16);
    check("flush_done", {15'd0, load_done}, 16'd1);
    check("flush_ready", {15'd0, load_ready}, 16'd0);
    check("flush_setpc", {15'd0, set_pc}, 16'd1);
    check("flush_ins", {7'd0, INS}, 16'd0);
    tick();
    check("run_done", {15'd0, load_done}, 16'd0);
    check("run_setpc", {15'd0, set_pc}, 16'd0);
    check("run_ready", {15'd0, load_ready}, 16'd0);
  endtask

  task automatic verify_all();
    for (int a = 0; a < 16; a++) begin
      PC_CURR = a[3:0];
      tick();
      check("fetch", {7'd0, INS}, {7'd0, exp_mem[a]});
    end
    PC_CURR = 4'd0;
  endtask

  initial begin
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 9'd0;
    load_par   = 1'b0;
    PC_CURR    = 4'd0;
    tick();
    tick();
    check("rst_setpc", {15'd0, set_pc}, 16'd1);
    check("rst_ins", {7'd0, INS}, 16'd0);
    check("rst_ready", {15'd0, load_ready}, 16'd0);
    check("rst_done", {15'd0, load_done}, 16'd0);
    check("rst_perr", {15'd0, parity_err}, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_setpc", {15'd0, set_pc}, 16'd1);
    check("idle_ins", {7'd0, INS}, 16'd0);
    check("idle_ready", {15'd0, load_ready}, 16'd0);
    check("idle_done", {15'd0, load_done}, 16'd0);

    // Back-to-back load of 0x100+i, then fetch address 3.
    load_seq(1'b1, 9'h100, 9'd1, 1'b0);
    PC_CURR = 4'd3;
    tick();
    check("fetch_pc3", {7'd0, INS}, 16'h0103);
    PC_CURR = 4'd0;
    tick();
    check("fetch_pc0", {7'd0, INS}, 16'h0100);

    // Stalled load from RUN, valid toggling every other cycle.
    load_seq(1'b1, 9'h0a5, 9'd7, 1'b1);
    verify_all();

    // Abandon a load after 7 words with an asynchronous reset.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b1;
      load_data  = 9'h1f0 - i[8:0];
      load_par   = ^load_data;
      tick();
    end
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", {15'd0, load_ready}, 16'd0);
    check("arst_setpc", {15'd0, set_pc}, 16'd1);
    check("arst_ins", {7'd0, INS}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {15'd0, load_ready}, 16'd0);
    load_seq(1'b1, 9'h033, 9'd5, 1'b0);
    verify_all();

    // Reload requested from RUN while fetching address 5.
    PC_CURR    = 4'd5;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("reload_ins_mem5", {7'd0, INS}, {7'd0, exp_mem[5]});
    check("reload_setpc", {15'd0, set_pc}, 16'd1);
    check("reload_ready", {15'd0, load_ready}, 16'd1);
    tick();
    check("reload_ins_zero", {7'd0, INS}, 16'd0);
    check("reload_setpc2", {15'd0, set_pc}, 16'd1);
    PC_CURR = 4'd0;
    load_seq(1'b0, 9'h1c0, 9'd3, 1'b0);
    verify_all();
    check("perr_clean", {15'd0, parity_err}, 16'd0);

`ifdef IMEM_PARITY_EN
    // Word 9 = 9'h001 with load_par=0 has bad parity.
    bad_par_idx = 9;
    load_seq(1'b1, 9'h001 - 9'd9, 9'd1, 1'b0);
    bad_par_idx = -1;
    check("perr_before", {15'd0, parity_err}, 16'd0);
    PC_CURR = 4'd9;
    tick();
    check("perr_ins9", {7'd0, INS}, 16'h0001);
    check("perr_set", {15'd0, parity_err}, 16'd1);
    PC_CURR = 4'd2;
    tick();
    tick();
    check("perr_sticky", {15'd0, parity_err}, 16'd1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("perr_cleared", {15'd0, parity_err}, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port load_start, input, 1 bit: single-cycle request to begin a program load.
REQ-004 SHALL have port load_valid, input, 1 bit: loader holds a valid word on load_data and load_par.
REQ-005 SHALL have port load_data, input, 9 bits: instruction word to store.
REQ-006 SHALL have port load_par, input, 1 bit: even-parity bit supplied with load_data.
REQ-007 SHALL have port load_ready, output, 1 bit: block accepts a load word this cycle.
REQ-008 SHALL have port PC_CURR, input, 4 bits: fetch address from the program counter.
REQ-009 SHALL have port INS, output, 9 bits: registered fetched instruction.
REQ-010 SHALL have port set_pc, output, 1 bit: holds the CPU program counter at 0.
REQ-011 SHALL have port load_done, output, 1 bit: single-cycle pulse when a load completes.
REQ-012 SHALL have port parity_err, output, 1 bit: sticky fetch parity error flag.

Function
REQ-013 SHALL hold 16 words x 9 bits of instruction storage, addressed 0..15.
REQ-014 SHALL implement FSM states IDLE, LOAD, FLUSH and RUN.
REQ-015 IDLE SHALL go to LOAD on load_start; LOAD SHALL go to FLUSH after the 16th accepted word; FLUSH SHALL go to RUN after exactly 1 cycle; RUN SHALL go to LOAD on load_start.
REQ-016 load_start SHALL be ignored in LOAD and FLUSH.
REQ-017 load_ready SHALL be 1 only in LOAD; a word SHALL transfer on any rising edge with load_valid=1 and load_ready=1.
REQ-018 Each transfer SHALL write the word to the address held in a 4-bit write pointer, then increment that pointer.
REQ-019 The write pointer SHALL be cleared to 0 on entry to LOAD, and SHALL wrap from 15 to 0 on the 16th transfer, which also triggers the move to FLUSH.
REQ-020 A load_valid=0 cycle in LOAD SHALL stall without side effects; there is no timeout.
REQ-021 In RUN, INS SHALL take mem[PC_CURR] at every rising edge (latency 1 cycle, no bypass).
REQ-022 In IDLE, LOAD and FLUSH, INS SHALL be 9'b0.
REQ-023 set_pc SHALL be 1 in IDLE, LOAD and FLUSH, and 0 in RUN, so the first RUN fetch is from address 0.
REQ-024 load_done SHALL be 1 only during the FLUSH cycle.
REQ-025 A read in RUN and a reload requested on the same edge SHALL be resolved as follows: INS is updated from the read, and the state moves to LOAD.

Reset
REQ-026 While rst_n=0: state SHALL be IDLE, write pointer 0, INS 9'b0, set_pc 1, load_ready 0, load_done 0, parity_err 0.
REQ-027 Reset SHALL NOT clear the storage array; a reset in the middle of a load SHALL abandon the load, and the words already written SHALL remain.

Configuration
REQ-028 The macro IMEM_PARITY_EN SHALL compile the parity feature in or out.
REQ-029 With IMEM_PARITY_EN defined, each word SHALL store load_par as a 10th bit.
REQ-030 With IMEM_PARITY_EN defined, each RUN fetch SHALL compute the XOR of the 9 data bits and the stored parity bit; a result of 1 SHALL set parity_err on the same edge that INS updates.
REQ-031 With IMEM_PARITY_EN defined, parity_err SHALL stay set until reset or the next entry to LOAD.
REQ-032 Without IMEM_PARITY_EN, there SHALL be no parity storage, load_par SHALL be ignored, and parity_err SHALL be constant 0.

Verification
REQ-033 Reset then idle 5 cycles -> set_pc=1, INS=0, load_ready=0, load_done=0.
REQ-034 load_start, then 16 back-to-back words of value 9'h100+i -> load_done pulses exactly one cycle after the 16th transfer; next cycle set_pc=0; PC_CURR=3 gives INS=9'h103 one edge later.
REQ-035 Load with load_valid toggling every other cycle -> exactly 16 transfers accepted; the storage array matches the words accepted; load_ready stays 1 throughout LOAD.
REQ-036 Assert rst_n=0 after 7 words, then perform a full reload -> the new contents are correct and no word is offset.
REQ-037 In RUN, load_start while PC_CURR=5 -> INS shows mem[5] for one edge, then INS=0 and set_pc=1 until the reload's FLUSH completes.
REQ-038 With IMEM_PARITY_EN: load word 9 as 9'h001 with load_par=0 -> fetch at PC_CURR=9 sets parity_err, which stays 1 until the next load_start.
